// File: rtl/clk_div_pkg.sv
// Shared constants and types for the clock-enable divider bank.
package clk_div_pkg;

  localparam int CNT_W_DEF = 27;

  // Divisors giving the named tick rate from a 50 MHz board clock
  localparam logic [CNT_W_DEF-1:0] DIV_1HZ    = 27'd50_000_000;
  localparam logic [CNT_W_DEF-1:0] DIV_1KHZ   = 27'd50_000;
  localparam logic [CNT_W_DEF-1:0] DIV_100KHZ = 27'd500;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] cnt;
    logic [CNT_W_DEF-1:0] div_act;
    logic [CNT_W_DEF-1:0] div_pend;
    logic                 src;
  } chan_state_t;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, staged divisor/source and registered tick/square outputs.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  input  logic             wr_src,
  input  logic             restart,
  input  logic             en,
  input  logic             prev_tick,
  output logic             tick,
  output logic             clk_sq
);

  localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [CNT_W-1:0] div_act_r, div_act_s;
  logic [CNT_W-1:0] div_pend_r, div_pend_s;
  logic             src_act_r, src_act_s;
  logic             src_pend_r, src_pend_s;
  logic             tick_r, tick_s;
  logic             sq_r, sq_s;
  logic             adv_s;

  // Next-state: restart, stopped/paused, terminal count, count
  always_comb begin
    div_pend_s = wr ? wr_div : div_pend_r;
    src_pend_s = wr ? wr_src : src_pend_r;
    adv_s      = en & (~src_act_r | prev_tick);
    cnt_s      = cnt_r;
    div_act_s  = div_act_r;
    src_act_s  = src_act_r;
    tick_s     = 1'b0;
    sq_s       = sq_r;
    if (restart) begin
      cnt_s     = ZERO;
      sq_s      = 1'b0;
      div_act_s = div_pend_s;
      src_act_s = src_pend_s;
    end else if (div_act_r == ZERO) begin
      // A stopped channel picks up a new divisor without waiting for a terminal count
      if (div_pend_r != ZERO) begin
        div_act_s = div_pend_r;
        src_act_s = src_pend_r;
        cnt_s     = ZERO;
      end else begin
        cnt_s = cnt_r;
      end
    end else if (!adv_s) begin
      cnt_s = cnt_r;
    end else if (cnt_r == div_act_r - ONE) begin
      cnt_s     = ZERO;
      tick_s    = 1'b1;
      sq_s      = ~sq_r;
      div_act_s = div_pend_r;
      src_act_s = src_pend_r;
    end else begin
      cnt_s = cnt_r + ONE;
    end
  end

  // Channel state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= ZERO;
      div_act_r  <= ZERO;
      div_pend_r <= ZERO;
      src_act_r  <= 1'b0;
      src_pend_r <= 1'b0;
      tick_r     <= 1'b0;
      sq_r       <= 1'b0;
    end else begin
      cnt_r      <= cnt_s;
      div_act_r  <= div_act_s;
      div_pend_r <= div_pend_s;
      src_act_r  <= src_act_s;
      src_pend_r <= src_pend_s;
      tick_r     <= tick_s;
      sq_r       <= sq_s;
    end
  end

  assign tick   = tick_r;
  assign clk_sq = sq_r;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH programmable clock-enable generators with config decode and cfg_err.
// Define CLK_DIV_CASCADE_EN to add cfg_src, letting channel k>0 count ticks of channel k-1.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
`ifdef CLK_DIV_CASCADE_EN
  input  logic              cfg_src,
`endif
  input  logic              sync_restart,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_sq,
  output logic              cfg_err
);

  localparam logic [CH_W:0] NUM_CH_V = (CH_W + 1)'(NUM_CH);

  logic              ch_oor_s;
  logic              cfg_src_s;
  logic              cfg_err_r;
  logic [NUM_CH-1:0] tick_s;

  assign ch_oor_s = ({1'b0, cfg_ch} >= NUM_CH_V);

`ifdef CLK_DIV_CASCADE_EN
  assign cfg_src_s = cfg_src;
`else
  assign cfg_src_s = 1'b0;
`endif

  // Flag writes addressed beyond the last channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err_r <= 1'b0;
    end else begin
      cfg_err_r <= cfg_we & ch_oor_s;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic wr_s;
    logic prev_s;
    logic src_s;

    assign wr_s = cfg_we & ~ch_oor_s & (cfg_ch == CH_W'(k));

    // Channel 0 has no upstream channel to cascade from
    if (k == 0) begin : g_head
      assign prev_s = 1'b0;
      assign src_s  = 1'b0;
    end else begin : g_tail
      assign prev_s = tick_s[k-1];
      assign src_s  = cfg_src_s;
    end

    clk_div_chan #(.CNT_W(CNT_W)) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr        (wr_s),
      .wr_div    (cfg_div),
      .wr_src    (src_s),
      .restart   (sync_restart),
      .en        (ch_en[k]),
      .prev_tick (prev_s),
      .tick      (tick_s[k]),
      .clk_sq    (clk_sq[k])
    );
  end

  assign tick    = tick_s;
  assign cfg_err = cfg_err_r;

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed scoreboard bench for clk_div_bank (NUM_CH=4, CH_W widened to 3 to reach cfg_ch=4).
module tb_clk_div_bank;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 27;
  localparam int CH_W   = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_we = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_div = '0;
  logic              cfg_src = 1'b0;
  logic              sync_restart = 1'b0;
  logic [NUM_CH-1:0] ch_en = '0;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] clk_sq;
  logic              cfg_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_t;
  sb_t sb_q[$];

  always #5 clk = ~clk;

  clk_div_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we       (cfg_we),
    .cfg_ch       (cfg_ch),
    .cfg_div      (cfg_div),
`ifdef CLK_DIV_CASCADE_EN
    .cfg_src      (cfg_src),
`endif
    .sync_restart (sync_restart),
    .ch_en        (ch_en),
    .tick         (tick),
    .clk_sq       (clk_sq),
    .cfg_err      (cfg_err)
  );

  task automatic push(input string tag, input logic [15:0] exp);
    sb_q.push_back('{tag, exp});
  endtask

  task automatic check(input logic [15:0] obs);
    sb_t e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  // One clock edge; strobes are dropped afterwards and outputs are sampled at the negedge
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    cfg_we       = 1'b0;
    sync_restart = 1'b0;
    cfg_src      = 1'b0;
  endtask

  task automatic drive_wr(input int ch, input int div, input logic src);
    cfg_we  = 1'b1;
    cfg_ch  = CH_W'(ch);
    cfg_div = CNT_W'(div);
    cfg_src = src;
  endtask

  initial begin
    int nt;
    int tk;
    int sq;
    int t0;
    int t1;

    repeat (2) @(negedge clk);
    push("reset_state", 16'd0);
    check(16'({cfg_err, clk_sq, tick}));
    rst_n = 1'b1;
    ch_en = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      push("post_reset_idle", 16'd0);
      cyc();
      check(16'({cfg_err, clk_sq, tick}));
    end

    // ch0 div=3: ticks every 3 cycles after load, clk_sq period 6
    drive_wr(0, 3, 1'b0);
    cyc();
    for (int i = 1; i <= 12; i++) begin
      nt = (i >= 4) ? (i - 1) / 3 : 0;
      tk = (i >= 4 && (i - 1) % 3 == 0) ? 1 : 0;
      push("ch0_div3", 16'(((nt % 2) << 4) | tk));
      cyc();
      check(16'({clk_sq, tick}));
    end

    // ch1 div=1: tick constant, clk_sq = clk/2
    drive_wr(1, 1, 1'b0);
    cyc();
    for (int j = 1; j <= 6; j++) begin
      tk = (j >= 2) ? 1 : 0;
      sq = (j >= 2) ? (j - 1) % 2 : 0;
      push("ch1_div1", 16'((sq << 1) | tk));
      cyc();
      check(16'({clk_sq[1], tick[1]}));
    end

    // ch1 div=0: finishes the in-flight period then holds clk_sq
    drive_wr(1, 0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      tk = (k <= 2) ? 1 : 0;
      sq = (k == 1) ? 0 : 1;
      push("ch1_stop", 16'((sq << 1) | tk));
      cyc();
      check(16'({clk_sq[1], tick[1]}));
    end

    // ch2 div=10 rewritten to 4 at cnt=5: first period stays 10
    drive_wr(2, 10, 1'b0);
    cyc();
    for (int c = 1; c <= 20; c++) begin
      if (c == 7) drive_wr(2, 4, 1'b0);
      tk = (c == 11 || c == 15 || c == 19) ? 1 : 0;
      sq = (c >= 11 && c <= 14) || (c >= 19) ? 1 : 0;
      push("ch2_rewrite", 16'((sq << 1) | tk));
      cyc();
      check(16'({clk_sq[2], tick[2]}));
    end

    // restart with a same-cycle write to ch1
    drive_wr(0, 5, 1'b0);
    cyc();
    drive_wr(1, 7, 1'b0);
    sync_restart = 1'b1;
    for (int r = 0; r <= 8; r++) begin
      t0 = (r == 5) ? 1 : 0;
      t1 = (r == 7) ? 1 : 0;
      sq = ((r >= 7 ? 1 : 0) << 1) | (r >= 5 ? 1 : 0);
      push("restart_phase", 16'((sq << 2) | (t1 << 1) | t0));
      cyc();
      check(16'({clk_sq[1:0], tick[1:0]}));
    end

    // ch0 div=8 with enable dropped for 4 cycles: interval stretches to 12
    drive_wr(0, 8, 1'b0);
    sync_restart = 1'b1;
    cyc();
    for (int c = 1; c <= 13; c++) begin
      ch_en[0] = (c >= 4 && c <= 7) ? 1'b0 : 1'b1;
      tk = (c == 12) ? 1 : 0;
      sq = (c >= 12) ? 1 : 0;
      push("ch0_pause", 16'((sq << 1) | tk));
      cyc();
      check(16'({clk_sq[0], tick[0]}));
    end

    // out-of-range write: cfg_err pulse, ch0 keeps its div=8 cadence
    drive_wr(4, 1, 1'b0);
    for (int e = 1; e <= 16; e++) begin
      tk = (e == 7 || e == 15) ? 1 : 0;
      push("cfg_oor", 16'((((e == 1) ? 1 : 0) << 2) | tk));
      cyc();
      check(16'({cfg_err, tick[3], tick[0]}));
    end

    // asynchronous reset mid-run clears outputs without a clock edge
    push("async_reset", 16'd0);
    #2 rst_n = 1'b0;
    #1 check(16'({cfg_err, clk_sq, tick}));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push("reset_release", 16'd0);
      cyc();
      check(16'({cfg_err, clk_sq, tick}));
    end

`ifdef CLK_DIV_CASCADE_EN
    // ch1 counts ch0 ticks: 5 x 3 = 15-cycle interval
    drive_wr(0, 5, 1'b0);
    cyc();
    drive_wr(1, 3, 1'b1);
    sync_restart = 1'b1;
    cyc();
    for (int r = 1; r <= 32; r++) begin
      tk = (r == 16 || r == 31) ? 1 : 0;
      push("cascade", 16'(tk));
      cyc();
      check(16'(tick[1]));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Parametrised bank of NUM_CH independent, runtime-programmable clock-enable generators, all driven from the board clock clk.
- Each channel produces a one-cycle tick strobe and a 50% square wave. These feed display scan, debounce, game-tick and buzzer logic.
- Replaces hard-coded fixed-ratio dividers. Ratios are written through a simple config port and are changed glitch-free.
- Channels can be phase-aligned with a single restart strobe.

Parameters:
- NUM_CH, 4, number of divider channels (1..16).
- CNT_W, 27, width of the divisor and counter per channel; covers 50 MHz to 1 Hz.
- CH_W, $clog2(NUM_CH) (minimum 1), width of the channel select.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-low.
- cfg_we  in  1  config write strobe, one cycle.
- cfg_ch  in  CH_W  channel addressed by cfg_we.
- cfg_div  in  CNT_W  divisor N for the addressed channel; 0 = channel stopped.
- sync_restart  in  1  one-cycle strobe; re-phases every channel.
- ch_en  in  NUM_CH  per-channel run enable.
- tick  out  NUM_CH  registered one-cycle pulse, every N enabled cycles.
- clk_sq  out  NUM_CH  registered square wave, toggles on each tick; period 2N.
- cfg_err  out  1  registered; high for 1 cycle when cfg_ch >= NUM_CH is written.

Behaviour:
- Reset: the following are all 0 for every channel, so every channel is stopped.
  - tick, clk_sq, cfg_err.
  - Counters cnt.
  - Active divisor div_act.
  - Pending divisor div_pend.
- Per channel, on each clk edge, evaluated in priority order:
  1. sync_restart: cnt<=0, clk_sq<=0, tick<=0, div_act<=div_pend. If a cfg write is in the same cycle, div_pend includes it.
  2. div_act==0, or ch_en low: cnt holds, tick<=0, clk_sq holds. Exception: if div_act==0 and div_pend!=0, load div_act<=div_pend and cnt<=0.
  3. cnt==div_act-1: cnt<=0, tick<=1, clk_sq<=~clk_sq, div_act<=div_pend.
  4. Otherwise: cnt<=cnt+1, tick<=0.
- Tick timing with N=1: tick is constantly high while enabled, and clk_sq toggles every cycle (clk/2).
- First-tick timing: after a channel starts from cnt=0 with N, the first tick is high on the cycle after the N-th enabled edge.
- Config write:
  - div_pend[cfg_ch]<=cfg_div.
  - Takes effect at the next terminal count, so there is never a truncated period or glitch on clk_sq.
  - Exception: a channel with div_act==0 loads one cycle after the write.
  - Writing 0 stops the channel at its next terminal count, with clk_sq held at its current level.
- Out-of-range cfg_ch: write is ignored and cfg_err pulses.
- Arithmetic:
  - cnt and div_act are unsigned CNT_W.
  - Compare against div_act-1 is computed only when div_act!=0; no wrap-around is possible.
- Reset mid-operation: asynchronous clear to the reset state. No tick is emitted on deassertion.
- ch_en toggling mid-period: counting pauses and resumes from the held cnt; the period is stretched, not restarted.

Optional Feature:
- Macro: CLK_DIV_CASCADE_EN.
- Defined:
  - Adds input cfg_src (1 bit), written alongside cfg_div into a per-channel src_pend.
  - For channel k>0, src=1 makes the counter advance only on cycles where tick[k-1] is high, instead of every clk. This gives ratios beyond 2^CNT_W.
  - src_act updates together with div_act.
  - Channel 0 ignores src.
- Undefined: the port is absent and all channels count clk.

Decomposition:
- Package clk_div_pkg:
  - CNT_W default.
  - Common divisor constants: DIV_1HZ=50_000_000, DIV_1KHZ=50_000, DIV_100KHZ=500 (tick-rate values at 50 MHz).
  - Channel-state struct: cnt, div_act, div_pend, src.
- Natural sub-module: clk_div_chan, a single channel with its counter, divisor staging and outputs.
  - The top level generates NUM_CH instances plus config decode and cfg_err.

Test Plan:
- Reset, then write ch0 div=3, ch_en=1111 -> tick[0] high on cycles 3, 6, 9…; clk_sq[0] period 6 cycles; all other ticks stay 0.
- ch1 div=1 -> tick[1] constantly 1 and clk_sq[1] = clk/2. Then write div=0 -> tick[1] stops after its current period; clk_sq[1] holds.
- ch2 running div=10, rewrite div=4 at cnt=5 -> remaining period completes at 10 cycles, subsequent periods are 4; no short pulse on clk_sq.
- ch0 div=5, ch1 div=7 running, assert sync_restart -> both cnt=0 and clk_sq=0 next cycle; ticks at +5 and +7 cycles.
- Drop ch_en[0] for 4 cycles mid-period (div=8) -> the tick interval measures 12 cycles. Write cfg_ch=4 with NUM_CH=4 -> cfg_err pulses 1 cycle and no state changes.
- CLK_DIV_CASCADE_EN: ch0 div=5, ch1 div=3 src=1 -> tick[1] every 15 cycles. Assert rst_n low mid-run -> all outputs 0 immediately.
